debug_display_mux: RTL and testbench

- Next-generation board debug display for the DE-series top level. It multiplexes NCH parametrised-width debug channels (PC, instruction, register read-out, etc.) onto NDIG seven-segment digits.
- Adds debounced push-button control, manual/auto-scroll channel selection, multi-page viewing of values wider than the display, and a freeze (hold) snapshot.
- Sits between the CPU debug outputs and the HEX pins.

---
 rtl/debug_display_pkg.sv | 22 ++
 rtl/key_debouncer.sv | 63 ++++++
 rtl/debug_display_mux.sv | 149 ++++++++++++++
 tb/tb_debug_display_mux.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_display_pkg.sv
// Shared types and constants for the board debug display.
package debug_display_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // Active-low {g,f,e,d,c,b,a} glyphs, entry n shows hex digit n
  localparam logic [15:0][6:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned KEY_NEXT = 0;
  localparam int unsigned KEY_MODE = 1;
  localparam int unsigned KEY_HOLD = 2;
  localparam int unsigned KEY_PAGE = 3;

endpackage

// File: rtl/key_debouncer.sv
// Synchronises one active-low push button, debounces it and emits a
// single-cycle pulse on each debounced press.
module key_debouncer #(
  parameter int unsigned DEB_CYC = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int unsigned CNTW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEB_CYC - 1);

  logic            meta_q, sync_q, last_q;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      last_q  <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= key_n;
      sync_q  <= meta_q;
      last_q  <= sync_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter measures how long the synchronised level has differed
  // from the accepted level without any further change.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = cnt_q;
    if (sync_q != last_q) begin
      cnt_d = '0;
    end else if (sync_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_q;
        press_d = ~sync_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/debug_display_mux.sv
// Multiplexes NCH debug channels onto NDIG seven-segment digits with
// debounced channel/page/mode/hold buttons and auto-scroll.
module debug_display_mux
  import debug_display_pkg::*;
#(
  parameter int unsigned NCH        = 4,
  parameter int unsigned DW         = 32,
  parameter int unsigned NDIG       = 6,
  parameter int unsigned DEB_CYC    = 500000,
  parameter int unsigned SCROLL_CYC = 50000000,
  localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned NPAGE = (DW + 4*NDIG - 1) / (4*NDIG),
  localparam int unsigned PW    = (NPAGE > 1) ? $clog2(NPAGE) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH*DW-1:0]    ch_data,
  input  logic [3:0]           key_n,
  output logic [NDIG*8-1:0]    hex,
  output logic [CW-1:0]        sel_ch,
  output logic [PW-1:0]        page,
  output logic                 auto_mode,
  output logic                 hold
);

  localparam int unsigned NNIB = DW / 4;
  localparam int unsigned SW   = (SCROLL_CYC > 1) ? $clog2(SCROLL_CYC) : 1;
  localparam logic [SW-1:0] SCROLL_MAX = SW'(SCROLL_CYC - 1);
  localparam logic [CW-1:0] SEL_MAX    = CW'(NCH - 1);
  localparam logic [PW-1:0] PAGE_MAX   = PW'(NPAGE - 1);

  logic [3:0] key_press;
  logic [3:0] unused_key_level;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debouncer #(.DEB_CYC(DEB_CYC)) u_deb (
      .clock (clock),
      .reset (reset),
      .key_n (key_n[k]),
      .level (unused_key_level[k]),
      .press (key_press[k])
    );
  end

  mode_e              mode_q, mode_d;
  logic [SW-1:0]      scroll_q, scroll_d;
  logic [CW-1:0]      sel_q, sel_d;
  logic [PW-1:0]      page_q, page_d;
  logic               hold_q, hold_d;
  logic               reload_q, reload_d;
  logic [DW-1:0]      snap_q, snap_d;
  logic [NDIG*8-1:0]  hex_q, hex_d;
  logic [DW-1:0]      cur_ch;
  logic               tick, advance;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q   <= MODE_MANUAL;
      scroll_q <= '0;
      sel_q    <= '0;
      page_q   <= '0;
      hold_q   <= 1'b0;
      reload_q <= 1'b0;
      snap_q   <= '0;
      hex_q    <= '1;
    end else begin
      mode_q   <= mode_d;
      scroll_q <= scroll_d;
      sel_q    <= sel_d;
      page_q   <= page_d;
      hold_q   <= hold_d;
      reload_q <= reload_d;
      snap_q   <= snap_d;
      hex_q    <= hex_d;
    end
  end

  always_comb begin
    cur_ch = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (sel_q == CW'(k)) cur_ch = ch_data[k*DW +: DW];
    end
  end

  assign tick    = (mode_q == MODE_AUTO) && (scroll_q == SCROLL_MAX);
  assign advance = key_press[KEY_NEXT] || tick;

  always_comb begin
    mode_d   = mode_q;
    scroll_d = scroll_q;
    sel_d    = sel_q;
    page_d   = page_q;
    hold_d   = hold_q;
    reload_d = 1'b0;

    case (mode_q)
      MODE_MANUAL: begin
        scroll_d = '0;
        if (key_press[KEY_MODE]) mode_d = MODE_AUTO;
      end
      MODE_AUTO: begin
        scroll_d = advance ? '0 : scroll_q + 1'b1;
        if (key_press[KEY_MODE]) begin
          mode_d   = MODE_MANUAL;
          scroll_d = '0;
        end
      end
    endcase

    // A held snapshot still follows a channel advance: it reloads once
    // in the cycle after sel updates, then stays frozen.
    if (advance) begin
      sel_d    = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
      reload_d = hold_q;
    end
    if (key_press[KEY_PAGE]) page_d = (page_q == PAGE_MAX) ? '0 : page_q + 1'b1;
    if (key_press[KEY_HOLD]) hold_d = ~hold_q;

    snap_d = (!hold_q || reload_q) ? cur_ch : snap_q;
  end

  always_comb begin : p_decode
    logic [3:0] nib;
    logic       nib_ok;
    logic [6:0] seg;
    logic       dp;
    hex_d = '1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      nib    = '0;
      nib_ok = 1'b0;
      for (int unsigned j = 0; j < NNIB; j++) begin
        if (NDIG * 32'(page_q) + i == j) begin
          nib    = snap_q[j*4 +: 4];
          nib_ok = 1'b1;
        end
      end
      seg = nib_ok ? GLYPH[nib] : SEG_BLANK;
      dp  = !((i == 0 && hold_q) || (i == NDIG - 1 && mode_q == MODE_AUTO));
      hex_d[i*8 +: 8] = {dp, seg};
    end
  end

  assign hex       = hex_q;
  assign sel_ch    = sel_q;
  assign page      = page_q;
  assign auto_mode = (mode_q == MODE_AUTO);
  assign hold      = hold_q;

endmodule

// File: tb/tb_debug_display_mux.sv
// Scoreboard bench for debug_display_mux with short debounce/scroll windows.
module tb_debug_display_mux;

  logic        clock;
  logic        reset;
  logic [3:0]  key_n;
  logic [31:0] c0, c1, c2;
  logic [95:0] ch_data;
  logic [47:0] hex;
  logic [1:0]  sel_ch;
  logic [0:0]  page;
  logic        auto_mode;
  logic        hold;

  assign ch_data = {c2, c1, c0};

  debug_display_mux #(
    .NCH(3), .DW(32), .NDIG(6), .DEB_CYC(4), .SCROLL_CYC(20)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ch_data   (ch_data),
    .key_n     (key_n),
    .hex       (hex),
    .sel_ch    (sel_ch),
    .page      (page),
    .auto_mode (auto_mode),
    .hold      (hold)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum {F_HEX, F_SEL, F_PAGE, F_AUTO, F_HOLD, F_DP0, F_DP5} fld_e;
  typedef struct {
    fld_e        f;
    string       name;
    logic [47:0] exp;
  } item_t;

  item_t sb[$];
  logic  chk_req = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  function automatic logic [6:0] g7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [47:0] mkhex(input logic [31:0] v, input int pg,
                                        input bit h, input bit a);
    logic [47:0] r;
    logic [6:0]  s;
    int          idx;
    for (int i = 0; i < 6; i++) begin
      idx = pg * 6 + i;
      s = (idx < 8) ? g7(v[idx*4 +: 4]) : 7'h7F;
      r[i*8 +: 8] = {!((i == 0 && h) || (i == 5 && a)), s};
    end
    return r;
  endfunction

  task automatic want(input string name, input fld_e f, input logic [47:0] v);
    item_t it;
    it.f = f; it.name = name; it.exp = v;
    sb.push_back(it);
  endtask

  task automatic sample();
    chk_req = 1'b1;
    @(negedge clock);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic press(input int k);
    key_n[k] = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    key_n[k] = 1'b1;
    repeat (12) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (chk_req) begin
      while (sb.size() > 0) begin
        item_t       it;
        logic [47:0] act;
        it = sb.pop_front();
        case (it.f)
          F_HEX:   act = hex;
          F_SEL:   act = 48'(sel_ch);
          F_PAGE:  act = 48'(page);
          F_AUTO:  act = 48'(auto_mode);
          F_HOLD:  act = 48'(hold);
          F_DP0:   act = 48'(hex[7]);
          default: act = 48'(hex[47]);
        endcase
        n_checks++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h, expected %0h", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] prev, v;
    int         vi;
    bit         seen;

    reset = 1'b0;
    key_n = 4'hF;
    c0 = 32'h12345678;
    c1 = 32'hDEADBEEF;
    c2 = 32'h00C0FFEE;

    #2;
    want("rst_hex", F_HEX, 48'hFFFFFFFFFFFF);
    want("rst_sel", F_SEL, 48'd0);
    want("rst_page", F_PAGE, 48'd0);
    want("rst_auto", F_AUTO, 48'd0);
    want("rst_hold", F_HOLD, 48'd0);
    sample();

    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    want("first_hex", F_HEX, mkhex(c0, 0, 0, 0));
    want("first_sel", F_SEL, 48'd0);
    want("first_page", F_PAGE, 48'd0);
    sample();

    // Bounce: two low cycles must not register.
    key_n[0] = 1'b0;
    repeat (2) @(posedge clock); #1;
    key_n[0] = 1'b1;
    repeat (2) @(posedge clock); #1;
    press(0);
    want("adv1_sel", F_SEL, 48'd1);
    want("adv1_hex", F_HEX, mkhex(c1, 0, 0, 0));
    sample();
    press(0);
    want("adv2_sel", F_SEL, 48'd2);
    want("adv2_hex", F_HEX, mkhex(c2, 0, 0, 0));
    sample();
    press(0);
    want("wrap_sel", F_SEL, 48'd0);
    sample();

    press(0);
    press(3);
    want("page1", F_PAGE, 48'd1);
    want("page1_hex", F_HEX, mkhex(c1, 1, 0, 0));
    sample();
    press(3);
    want("page0", F_PAGE, 48'd0);
    want("page0_hex", F_HEX, mkhex(c1, 0, 0, 0));
    sample();
    press(0);
    press(0);
    want("back_ch0", F_SEL, 48'd0);
    sample();

    press(2);
    want("hold_on", F_HOLD, 48'd1);
    want("hold_hex", F_HEX, mkhex(32'h12345678, 0, 1, 0));
    sample();
    c0 = 32'hFFFFFFFF;
    repeat (4) @(posedge clock);
    want("hold_frozen", F_HEX, mkhex(32'h12345678, 0, 1, 0));
    sample();
    press(0);
    want("hold_adv_sel", F_SEL, 48'd1);
    want("hold_adv_hex", F_HEX, mkhex(32'hDEADBEEF, 0, 1, 0));
    sample();
    c1 = 32'h11111111;
    repeat (4) @(posedge clock);
    want("hold_frozen2", F_HEX, mkhex(32'hDEADBEEF, 0, 1, 0));
    sample();
    press(2);
    want("hold_off", F_HOLD, 48'd0);
    want("unhold_hex", F_HEX, mkhex(32'h11111111, 0, 0, 0));
    sample();

    press(1);
    want("auto_on", F_AUTO, 48'd1);
    want("auto_dp5", F_DP5, 48'd0);
    sample();

    prev = sel_ch;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clock); #1;
      if (sel_ch != prev) seen = 1'b1;
    end
    if (!seen) begin
      n_fail++;
      $display("FAIL scroll_wait: got no channel change, expected one within 60 cycles");
    end
    v  = sel_ch;
    vi = int'(v);
    repeat (19) @(posedge clock);
    want("dwell_sel", F_SEL, 48'(vi));
    sample();
    @(posedge clock);
    want("scroll_step", F_SEL, 48'((vi + 1) % 3));
    sample();

    // Press timed so its event lands on the same edge as the next tick.
    repeat (12) @(posedge clock); #1;
    key_n[0] = 1'b0;
    repeat (12) @(posedge clock); #1;
    want("coincide_sel", F_SEL, 48'((vi + 2) % 3));
    sample();
    key_n[0] = 1'b1;
    repeat (15) @(posedge clock);
    want("post_dwell", F_SEL, 48'((vi + 2) % 3));
    sample();
    @(posedge clock);
    want("post_step", F_SEL, 48'(vi));
    sample();

    press(3);
    press(2);
    want("pre_rst_page", F_PAGE, 48'd1);
    want("pre_rst_hold", F_HOLD, 48'd1);
    want("pre_rst_auto", F_AUTO, 48'd1);
    want("pre_rst_dp0", F_DP0, 48'd0);
    sample();

    key_n[0] = 1'b0;
    repeat (3) @(posedge clock); #1;
    reset = 1'b0;
    want("async_hex", F_HEX, 48'hFFFFFFFFFFFF);
    want("async_sel", F_SEL, 48'd0);
    want("async_page", F_PAGE, 48'd0);
    want("async_auto", F_AUTO, 48'd0);
    want("async_hold", F_HOLD, 48'd0);
    sample();
    key_n = 4'hF;
    repeat (4) @(posedge clock); #1;
    reset = 1'b1;
    repeat (30) @(posedge clock);
    want("post_rst_sel", F_SEL, 48'd0);
    want("post_rst_page", F_PAGE, 48'd0);
    want("post_rst_auto", F_AUTO, 48'd0);
    want("post_rst_hold", F_HOLD, 48'd0);
    want("post_rst_hex", F_HEX, mkhex(32'hFFFFFFFF, 0, 0, 0));
    sample();

    @(negedge clock);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
